// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and round constants for the Ascon-128 control FSM.
// Imported by the FSM top and its round counter.
package ascon_pack;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_WAIT_PT,
    S_PT,
    S_FINAL,
    S_DONE
  } fsm_state_t;

  localparam logic [3:0] ROUND_PA_FIRST = 4'd0;
  localparam logic [3:0] ROUND_PB_FIRST = 4'd6;
  localparam logic [3:0] ROUND_LAST     = 4'd11;

  // Saturating step: the counter parks on the last round.
  function automatic logic [3:0] round_step(
    input logic [3:0] r
  );
    return (r >= ROUND_LAST) ? ROUND_LAST : r + 4'd1;
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Loadable round counter for the Ascon permutation.
// A load presents the load value in the same cycle.
module round_counter
  import ascon_pack::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic [3:0] o_round,
  output logic       o_last
);

  logic [3:0] r_round;
  logic [3:0] w_round;

  assign w_round = i_load ? i_load_val : r_round;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_round <= '0;
    end else if (i_load || i_en) begin
      r_round <= round_step(w_round);
    end
  end

  assign o_round = w_round;
  assign o_last  = (w_round == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 control FSM: init, one AD block, NB_PT_BLOCKS plaintext
// blocks and finalisation, one permutation round per clock.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_PT_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       select_o,
  output logic       en_state_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_lsb_end_o,
  output logic       en_xor_key_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       done_o
);

  localparam int BW = $clog2(NB_PT_BLOCKS) + 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(NB_PT_BLOCKS - 1);

  fsm_state_t r_state;
  fsm_state_t w_next;

  logic [BW-1:0] r_blk_cnt;
  logic          r_cipher_valid;
  logic          r_tag_valid;

  logic          w_load;
  logic [3:0]    w_load_val;
  logic          w_cnt_en;
  logic          w_last;
  logic [3:0]    w_round;
  logic          w_blk_clr;
  logic          w_blk_inc;
  logic          w_start_acc;

  round_counter u_round (
    .i_clk      (clock_i),
    .i_rst      (reset_i),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_cnt_en),
    .o_round    (w_round),
    .o_last     (w_last)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_blk_cnt <= '0;
    end else if (w_blk_clr) begin
      r_blk_cnt <= '0;
    end else if (w_blk_inc) begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  // Tag stays readable after done until the next message starts.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_cipher_valid <= 1'b0;
      r_tag_valid    <= 1'b0;
    end else begin
      r_cipher_valid <= en_cipher_o;
      if (en_tag_o) begin
        r_tag_valid <= 1'b1;
      end else if (w_start_acc) begin
        r_tag_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next              = r_state;
    w_load              = 1'b0;
    w_load_val          = ROUND_PA_FIRST;
    w_cnt_en            = 1'b0;
    w_blk_clr           = 1'b0;
    w_blk_inc           = 1'b0;
    w_start_acc         = 1'b0;
    data_ready_o        = 1'b0;
    select_o            = 1'b0;
    en_state_o          = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    done_o              = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          w_load      = 1'b1;
          w_load_val  = ROUND_PA_FIRST;
          select_o    = 1'b1;
          en_state_o  = 1'b1;
          w_next      = S_INIT;
        end
      end
      S_INIT: begin
        en_state_o = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_last) begin
          en_xor_key_end_o = 1'b1;
          w_next           = S_WAIT_AD;
        end
      end
      S_WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          w_load              = 1'b1;
          w_load_val          = ROUND_PB_FIRST;
          en_xor_data_begin_o = 1'b1;
          en_state_o          = 1'b1;
          w_next              = S_AD;
        end
      end
      S_AD: begin
        en_state_o = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_last) begin
          en_xor_lsb_end_o = 1'b1;
          w_blk_clr        = 1'b1;
          w_next           = S_WAIT_PT;
        end
      end
      S_WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          w_load              = 1'b1;
          en_xor_data_begin_o = 1'b1;
          en_cipher_o         = 1'b1;
          en_state_o          = 1'b1;
          // The last block is absorbed straight into finalisation.
          if (r_blk_cnt == LAST_BLK) begin
            w_load_val         = ROUND_PA_FIRST;
            en_xor_key_begin_o = 1'b1;
            w_next             = S_FINAL;
          end else begin
            w_load_val = ROUND_PB_FIRST;
            w_next     = S_PT;
          end
        end
      end
      S_PT: begin
        en_state_o = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_last) begin
          w_blk_inc = 1'b1;
          w_next    = S_WAIT_PT;
        end
      end
      S_FINAL: begin
        en_state_o = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_last) begin
          en_xor_key_end_o = 1'b1;
          en_tag_o         = 1'b1;
          w_next           = S_DONE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign round_o        = w_round;
  assign cipher_valid_o = r_cipher_valid;
  assign tag_valid_o    = r_tag_valid;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: per-cycle vector table on a 4-block
// instance, then reset and latency sequences on 4- and 1-block instances.
module tb_ascon_ctrl_fsm;

  localparam logic [11:0] RDY = 12'h800;
  localparam logic [11:0] SEL = 12'h400;
  localparam logic [11:0] ST  = 12'h200;
  localparam logic [11:0] XDB = 12'h100;
  localparam logic [11:0] XKB = 12'h080;
  localparam logic [11:0] XLE = 12'h040;
  localparam logic [11:0] XKE = 12'h020;
  localparam logic [11:0] CIP = 12'h010;
  localparam logic [11:0] TAG = 12'h008;
  localparam logic [11:0] CVL = 12'h004;
  localparam logic [11:0] TVL = 12'h002;
  localparam logic [11:0] DN  = 12'h001;

  typedef struct {
    logic       st;
    logic       vl;
    int         n;
    logic [3:0] r0;
    logic       inc;
    logic [11:0] f;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st4 = 1'b0, v4 = 1'b0;
  logic st1 = 1'b0, v1 = 1'b0;

  logic        rdy4, sel4, es4, xdb4, xkb4, xle4, xke4;
  logic        cip4, tag4, cv4, tv4, dn4;
  logic [3:0]  r4;
  logic        rdy1, sel1, es1, xdb1, xkb1, xle1, xke1;
  logic        cip1, tag1, cv1, tv1, dn1;
  logic [3:0]  r1;
  logic [11:0] f4, f1;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_PT_BLOCKS(4)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(st4), .data_valid_i(v4),
    .data_ready_o(rdy4), .round_o(r4), .select_o(sel4),
    .en_state_o(es4), .en_xor_data_begin_o(xdb4),
    .en_xor_key_begin_o(xkb4), .en_xor_lsb_end_o(xle4),
    .en_xor_key_end_o(xke4), .en_cipher_o(cip4), .en_tag_o(tag4),
    .cipher_valid_o(cv4), .tag_valid_o(tv4), .done_o(dn4)
  );

  ascon_ctrl_fsm #(.NB_PT_BLOCKS(1)) dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(st1), .data_valid_i(v1),
    .data_ready_o(rdy1), .round_o(r1), .select_o(sel1),
    .en_state_o(es1), .en_xor_data_begin_o(xdb1),
    .en_xor_key_begin_o(xkb1), .en_xor_lsb_end_o(xle1),
    .en_xor_key_end_o(xke1), .en_cipher_o(cip1), .en_tag_o(tag1),
    .cipher_valid_o(cv1), .tag_valid_o(tv1), .done_o(dn1)
  );

  assign f4 = {rdy4, sel4, es4, xdb4, xkb4, xle4, xke4,
               cip4, tag4, cv4, tv4, dn4};
  assign f1 = {rdy1, sel1, es1, xdb1, xkb1, xle1, xke1,
               cip1, tag1, cv1, tv1, dn1};

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic vl, input int n,
                     input logic [3:0] r0, input logic inc,
                     input logic [11:0] f);
    vec_t v;
    v.st = st; v.vl = vl; v.n = n; v.r0 = r0; v.inc = inc; v.f = f;
    tv.push_back(v);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1; st4 = 1'b0; v4 = 1'b0; st1 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_lat(input bit one, input int exp_lat,
                         input int exp_xkb, input int exp_nc);
    int lat = -1;
    int xkb = -1;
    int ncip = 0;
    int ncv = 0;
    logic [11:0] cur;
    @(posedge clk); #1;
    if (one) begin st1 = 1'b1; v1 = 1'b1; end
    else begin st4 = 1'b1; v4 = 1'b1; end
    @(negedge clk);
    for (int c = 1; c < 200 && lat < 0; c++) begin
      @(posedge clk); #1;
      st1 = 1'b0; st4 = 1'b0;
      @(negedge clk);
      cur = one ? f1 : f4;
      if ((cur & XKB) != 0 && xkb < 0) xkb = c;
      if ((cur & CIP) != 0) ncip++;
      if ((cur & CVL) != 0) ncv++;
      if ((cur & DN) != 0) lat = c;
    end
    v1 = 1'b0; v4 = 1'b0;
    chk(one ? "lat1_done" : "lat4_done", 0, 16'(lat), 16'(exp_lat));
    chk(one ? "lat1_xkb" : "lat4_xkb", 0, 16'(xkb), 16'(exp_xkb));
    chk(one ? "lat1_cip" : "lat4_cip", 0, 16'(ncip), 16'(exp_nc));
    chk(one ? "lat1_cvl" : "lat4_cvl", 0, 16'(ncv), 16'(exp_nc));
    @(negedge clk);
    chk(one ? "lat1_tv" : "lat4_tv", 0,
        {12'h0, 4'(one ? tv1 : tv4)}, 16'h1);
  endtask

  initial begin
    add(0, 0,  2,  0, 0, 0);
    add(1, 0,  1,  0, 0, SEL | ST);
    add(0, 0, 10,  1, 1, ST);
    add(0, 0,  1, 11, 0, ST | XKE);
    add(0, 0,  3, 11, 0, RDY);
    add(0, 1,  1,  6, 0, RDY | ST | XDB);
    add(0, 0,  4,  7, 1, ST);
    add(0, 0,  1, 11, 0, ST | XLE);
    add(0, 0,  3, 11, 0, RDY);
    add(0, 1,  1,  6, 0, RDY | ST | XDB | CIP);
    add(1, 0,  1,  7, 0, ST | CVL);
    add(0, 0,  4,  8, 1, ST);
    add(0, 0,  3, 11, 0, RDY);
    add(0, 1,  1,  6, 0, RDY | ST | XDB | CIP);
    add(0, 1,  1,  7, 0, ST | CVL);
    add(0, 1,  4,  8, 1, ST);
    add(0, 1,  1,  6, 0, RDY | ST | XDB | CIP);
    add(0, 0,  1,  7, 0, ST | CVL);
    add(0, 0,  4,  8, 1, ST);
    add(0, 0,  3, 11, 0, RDY);
    add(0, 1,  1,  0, 0, RDY | ST | XDB | XKB | CIP);
    add(1, 0,  1,  1, 0, ST | CVL);
    add(0, 0,  9,  2, 1, ST);
    add(1, 0,  1, 11, 0, ST | XKE | TAG);
    add(0, 0,  1, 11, 0, DN | TVL);
    add(0, 0,  2, 11, 0, TVL);
    add(1, 0,  1,  0, 0, SEL | ST | TVL);
    add(0, 0,  4,  1, 1, ST);

    @(negedge clk);
    chk("reset4", 0, {r4, f4}, 16'h0);
    chk("reset1", 0, {r1, f1}, 16'h0);
    #1 rst = 1'b0;

    foreach (tv[k]) begin
      for (int i = 0; i < tv[k].n; i++) begin
        @(posedge clk); #1;
        st4 = tv[k].st; v4 = tv[k].vl;
        @(negedge clk);
        chk("vec", k, {r4, f4},
            {tv[k].r0 + (tv[k].inc ? 4'(i) : 4'd0), tv[k].f});
      end
    end

    // Abort during INIT round 5, then restart from round 0.
    @(posedge clk); #1;
    st4 = 1'b0; v4 = 1'b0;
    chk("init_r5", 0, {r4, f4}, {4'd5, ST});
    rst = 1'b1;
    #1;
    chk("mid_reset", 0, {r4, f4}, 16'h0);
    @(negedge clk);
    chk("mid_reset_hold", 0, {r4, f4}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0; st4 = 1'b1;
    @(negedge clk);
    chk("restart", 0, {r4, f4}, {4'd0, SEL | ST});
    @(posedge clk); #1;
    st4 = 1'b0;
    @(negedge clk);
    chk("restart_r1", 0, {r4, f4}, {4'd1, ST});

    pulse_reset();
    run_lat(1'b0, 48, 36, 4);
    pulse_reset();
    run_lat(1'b1, 30, 18, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
